// File: rtl/bram_pkg.sv
// Shared types and byte helpers for the byte-enable block RAM.
package bram_pkg;

    typedef enum logic {RDW_READ_FIRST, RDW_WRITE_FIRST} rdw_mode_e;
    typedef enum logic {ST_CLEAR, ST_READY} bram_state_e;

    // Even parity: stored bit makes the XOR of the 9 bits zero.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

    function automatic logic [7:0] be_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
        return en ? new_b : old_b;
    endfunction

endpackage

// File: rtl/bram_clear_seq.sv
// Post-reset zero-clear sequencer: walks every address once, then reports ready.
module bram_clear_seq
    import bram_pkg::*;
#(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic                  clr_we_o,
    output logic [ADDR_WIDTH-1:0] clr_addr_o,
    output logic                  init_done_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    bram_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        clr_we_o    = 1'b0;
        init_done_o = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_we_o = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) state_d = ST_READY;
            end
            ST_READY: init_done_o = 1'b1;
            default:  state_d = ST_CLEAR;
        endcase
    end

    assign clr_addr_o = cnt_q;

endmodule

// File: rtl/bram_sdp_be.sv
// Simple dual-port RAM with byte enables, 1/2-cycle read latency and selectable
// read-during-write; optional per-byte even parity when BRAM_PARITY_EN is defined.
module bram_sdp_be
    import bram_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    output logic                    init_done_o,
    input  logic                    wr_en_i,
    input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
    input  logic [DATA_WIDTH/8-1:0] wr_be_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    input  logic                    rd_en_i,
    input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
    output logic [DATA_WIDTH-1:0]   rd_data_o,
    output logic                    rd_valid_o,
    output logic                    par_err_o
);

    localparam int        NB    = DATA_WIDTH / 8;
    localparam int        DEPTH = 2 ** ADDR_WIDTH;
    localparam rdw_mode_e RDW   = rdw_mode_e'(RDW_MODE[0]);
`ifdef BRAM_PARITY_EN
    localparam int        MEM_W = DATA_WIDTH + NB;   // parity bits sit above the data
`else
    localparam int        MEM_W = DATA_WIDTH;
`endif

    logic [MEM_W-1:0] mem [DEPTH];

    logic                  clr_we, wr_fire, rd_fire, we;
    logic [ADDR_WIDTH-1:0] clr_addr, wa;
    logic [MEM_W-1:0]      wr_word, wsel_word, rd_word;
    logic [NB-1:0]         wmask;

    bram_clear_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_clr (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clr_we_o    (clr_we),
        .clr_addr_o  (clr_addr),
        .init_done_o (init_done_o)
    );

    assign wr_fire = init_done_o & wr_en_i;
    assign rd_fire = init_done_o & rd_en_i;

    always_comb begin
        wr_word = '0;
        wr_word[DATA_WIDTH-1:0] = wr_data_i;
`ifdef BRAM_PARITY_EN
        for (int k = 0; k < NB; k++) wr_word[DATA_WIDTH+k] = byte_parity(wr_data_i[8*k +: 8]);
`endif
    end

    // Clear sequencer owns the write port until init completes; zero word has valid parity.
    always_comb begin
        we        = wr_fire;
        wa        = wr_addr_i;
        wsel_word = wr_word;
        wmask     = wr_be_i;
        if (clr_we) begin
            we        = 1'b1;
            wa        = clr_addr;
            wsel_word = '0;
            wmask     = '1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we) begin
            for (int k = 0; k < NB; k++) begin
                if (wmask[k]) begin
                    mem[wa][8*k +: 8] <= wsel_word[8*k +: 8];
`ifdef BRAM_PARITY_EN
                    mem[wa][DATA_WIDTH+k] <= wsel_word[DATA_WIDTH+k];
`endif
                end
            end
        end
    end

    always_comb begin
        rd_word = mem[rd_addr_i];
        if (RDW == RDW_WRITE_FIRST && wr_fire && rd_fire && wr_addr_i == rd_addr_i) begin
            for (int k = 0; k < NB; k++) begin
                rd_word[8*k +: 8] = be_merge(rd_word[8*k +: 8], wr_word[8*k +: 8], wr_be_i[k]);
`ifdef BRAM_PARITY_EN
                if (wr_be_i[k]) rd_word[DATA_WIDTH+k] = wr_word[DATA_WIDTH+k];
`endif
            end
        end
    end

    logic [READ_LATENCY:1] vld_q;
    logic [READ_LATENCY:0] vld_pipe;

    assign vld_pipe = {vld_q, rd_fire};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) vld_q <= '0;
        else         vld_q <= vld_pipe[READ_LATENCY-1:0];
    end

    // Each stage only advances on its valid bit, so the last stage holds between reads.
    for (genvar s = 0; s < READ_LATENCY; s++) begin : g_rd
        logic [MEM_W-1:0] q;
        logic [MEM_W-1:0] d;
        if (s == 0) begin : g_first
            assign d = rd_word;
        end else begin : g_next
            assign d = g_rd[s-1].q;
        end
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni)          q <= '0;
            else if (vld_pipe[s]) q <= d;
        end
    end

    logic [MEM_W-1:0] rd_out;
    assign rd_out     = g_rd[READ_LATENCY-1].q;
    assign rd_data_o  = rd_out[DATA_WIDTH-1:0];
    assign rd_valid_o = vld_pipe[READ_LATENCY];

`ifdef BRAM_PARITY_EN
    logic mism;
    always_comb begin
        mism = 1'b0;
        for (int k = 0; k < NB; k++)
            mism = mism | (byte_parity(rd_out[8*k +: 8]) != rd_out[DATA_WIDTH+k]);
    end
    assign par_err_o = rd_valid_o & mism;
`else
    assign par_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bram_sdp_be.sv
// Directed bench for bram_sdp_be: clear sequence, byte enables, collisions, streaming.
module tb_bram_sdp_be;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int LAT = 1;
    localparam int RDW = 0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init_done;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [3:0]    wr_be = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          par_err;

    int vec = 0;
    int mis = 0;

    always #5 clk = ~clk;

    bram_sdp_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(LAT), .RDW_MODE(RDW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .init_done_o (init_done),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .wr_be_i     (wr_be),
        .wr_data_i   (wr_data),
        .rd_en_i     (rd_en),
        .rd_addr_i   (rd_addr),
        .rd_data_o   (rd_data),
        .rd_valid_o  (rd_valid),
        .par_err_o   (par_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input logic exp_par,
                           input string nm);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
        repeat (LAT - 1) begin
            vec++;
            if (rd_valid !== 1'b0) begin
                mis++; $display("FAIL %s early_valid got=%b want=0", nm, rd_valid);
            end
            tick();
        end
        vec++;
        if (rd_valid !== 1'b1 || rd_data !== exp || par_err !== exp_par) begin
            mis++;
            $display("FAIL %s addr=%0d got valid=%b data=%h perr=%b want valid=1 data=%h perr=%b",
                     nm, a, rd_valid, rd_data, par_err, exp, exp_par);
        end
    endtask

    // Watch init_done across the 32-cycle clear that follows a release.
    task automatic wait_clear(input string nm);
        for (int i = 1; i <= 32; i++) begin
            tick();
            vec++;
            if (init_done !== (i == 32) || rd_valid !== 1'b0) begin
                mis++;
                $display("FAIL %s cycle=%0d got done=%b valid=%b want done=%b valid=0",
                         nm, i, init_done, rd_valid, (i == 32));
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        vec++;
        if (init_done !== 1'b0 || rd_valid !== 1'b0 || rd_data !== '0 || par_err !== 1'b0) begin
            mis++;
            $display("FAIL reset_vals got done=%b valid=%b data=%h perr=%b want 0/0/0/0",
                     init_done, rd_valid, rd_data, par_err);
        end
        rst_n = 1'b1;
        wait_clear("reset_clear");
        for (int a = 0; a < 32; a++) do_read(AW'(a), 32'h0, 1'b0, "init_zero");
    endtask

    task automatic test_byte_enable();
        do_write(5'd3, 32'hAABBCCDD, 4'hF);
        do_write(5'd3, 32'h11223344, 4'b0101);
        do_read(5'd3, 32'hAA22CC44, 1'b0, "be_merge");
        do_write(5'd3, 32'hFFFFFFFF, 4'b0000);
        do_read(5'd3, 32'hAA22CC44, 1'b0, "be_zero");
        do_write(5'd31, 32'hCAFEF00D, 4'hF);
        do_read(5'd31, 32'hCAFEF00D, 1'b0, "top_addr");
    endtask

    task automatic collide(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be,
                           input logic [DW-1:0] exp, input string nm);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        rd_en = 1'b1; rd_addr = a;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        repeat (LAT - 1) tick();
        vec++;
        if (rd_valid !== 1'b1 || rd_data !== exp) begin
            mis++;
            $display("FAIL %s got valid=%b data=%h want valid=1 data=%h", nm, rd_valid, rd_data, exp);
        end
    endtask

    task automatic test_collision();
        collide(5'd7, 32'hDEADBEEF, 4'hF, (RDW != 0) ? 32'hDEADBEEF : 32'h0, "coll_full");
        do_read(5'd7, 32'hDEADBEEF, 1'b0, "coll_after");
        collide(5'd9, 32'h12345678, 4'b0011, (RDW != 0) ? 32'h00005678 : 32'h0, "coll_part");
        do_read(5'd9, 32'h00005678, 1'b0, "coll_part_after");
        // different addresses: read sees stored word, write lands independently
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h0BADF00D; wr_be = 4'hF;
        rd_en = 1'b1; rd_addr = 5'd3;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        repeat (LAT - 1) tick();
        vec++;
        if (rd_valid !== 1'b1 || rd_data !== 32'hAA22CC44) begin
            mis++;
            $display("FAIL diff_addr got valid=%b data=%h want valid=1 data=aa22cc44", rd_valid, rd_data);
        end
        do_read(5'd10, 32'h0BADF00D, 1'b0, "diff_addr_wr");
    endtask

    task automatic test_reset_mid_clear();
        do_write(5'd20, 32'h5A5A5A5A, 4'hF);
        do_read(5'd20, 32'h5A5A5A5A, 1'b0, "garbage_wr");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        rst_n = 1'b0;
        #2;
        vec++;
        if (init_done !== 1'b0 || rd_valid !== 1'b0) begin
            mis++; $display("FAIL mid_clear_rst got done=%b valid=%b want 0/0", init_done, rd_valid);
        end
        rst_n = 1'b1;
        wait_clear("restart_clear");
        do_read(5'd20, 32'h0, 1'b0, "garbage_cleared");
        do_read(5'd3, 32'h0, 1'b0, "addr3_cleared");
    endtask

    task automatic test_back_to_back();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            if (i >= 3 && i <= 8) begin
                wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
                rd_en = 1'b1; rd_addr = 5'd4;
            end else begin
                wr_en = 1'b0; rd_en = 1'b0;
            end
            tick();
            vec++;
            if (rd_valid !== 1'b0 || init_done !== (i == 32)) begin
                mis++;
                $display("FAIL clear_ignore cycle=%0d got valid=%b done=%b want valid=0 done=%b",
                         i, rd_valid, init_done, (i == 32));
            end
        end
        do_read(5'd4, 32'h0, 1'b0, "clear_no_write");
        for (int i = 0; i < 16; i++) do_write(AW'(i), 32'hA5000000 + 32'(i * 3), 4'hF);
        for (int c = 0; c < 16 + LAT - 1; c++) begin
            rd_en   = (c < 16);
            rd_addr = AW'(c);
            tick();
            if (c >= LAT - 1) begin
                vec++;
                if (rd_valid !== 1'b1 || rd_data !== 32'hA5000000 + 32'((c - (LAT - 1)) * 3)) begin
                    mis++;
                    $display("FAIL stream idx=%0d got valid=%b data=%h want valid=1 data=%h",
                             c - (LAT - 1), rd_valid, rd_data, 32'hA5000000 + 32'((c - (LAT - 1)) * 3));
                end
            end
        end
        rd_en = 1'b0;
        tick();
        vec++;
        if (rd_valid !== 1'b0 || rd_data !== 32'hA5000000 + 32'd45) begin
            mis++;
            $display("FAIL stream_hold got valid=%b data=%h want valid=0 data=a500002d", rd_valid, rd_data);
        end
    endtask

    task automatic test_parity();
        do_write(5'd5, 32'h01020304, 4'hF);
`ifdef BRAM_PARITY_EN
        dut.mem[5][9] = ~dut.mem[5][9];
        do_read(5'd5, 32'h01020104, 1'b1, "parity_err");
`else
        do_read(5'd5, 32'h01020304, 1'b0, "parity_off");
`endif
        do_read(5'd6, 32'hA5000012, 1'b0, "parity_clean");
    endtask

    initial begin
        test_reset();
        test_byte_enable();
        test_collision();
        test_reset_mid_clear();
        test_back_to_back();
        test_parity();
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule
